// File: rtl/zqh_test_status_pkg.sv
// zqh_test_status_pkg
//   Shared constants for the test-status peripheral:
//   - register byte offsets (TOHOST, HEARTBEAT, WDOG_LIMIT, STATUS)
//   - bit positions inside the STATUS register
//   - bus handshake FSM state encoding
package zqh_test_status_pkg;

    localparam int unsigned OFF_TOHOST     = 32'h000;
    localparam int unsigned OFF_HEARTBEAT  = 32'h004;
    localparam int unsigned OFF_WDOG_LIMIT = 32'h008;
    localparam int unsigned OFF_STATUS     = 32'h00C;

    localparam int unsigned STAT_DONE_BIT  = 0;
    localparam int unsigned STAT_PASS_BIT  = 1;
    localparam int unsigned STAT_FIRED_BIT = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } bus_state_t;

endpackage

// File: rtl/zqh_test_status_wdog.sv
// zqh_test_status_wdog
//   Watchdog counter. Counts cycles while enabled and the limit is non-zero,
//   saturating at all-ones. A clear request has priority over counting.
//   o_expire is a single-cycle pulse during the cycle in which the counter
//   would step from limit-1 to limit.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_enable      counting allowed (low once the test has finished)
//   i_clear       restart the count from zero (heartbeat or limit write)
//   i_limit       expiry limit in cycles; 0 disables the watchdog
//   o_expire      expiry pulse
module zqh_test_status_wdog #(
    parameter int unsigned WDOG_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_clear,
    input  logic [WDOG_W-1:0] i_limit,
    output logic              o_expire
);

    logic [WDOG_W-1:0] r_cnt;
    logic              w_run;

    assign w_run = i_enable & (i_limit != '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (w_run && (r_cnt != '1)) begin
            r_cnt <= r_cnt + WDOG_W'(1);
        end
    end

    // A clear in the same cycle means the count never reaches the limit.
    assign o_expire = w_run & ~i_clear & (r_cnt == (i_limit - WDOG_W'(1)));

endmodule

// File: rtl/zqh_test_status_ctrl.sv
// zqh_test_status_ctrl
//   Memory-mapped test-status peripheral. Software reports pass/fail through
//   TOHOST and keeps the hardware watchdog alive through HEARTBEAT; the
//   watchdog ends a hung test with an all-ones failure code.
// Ports:
//   clock, reset              clock, asynchronous active-high reset
//   req_valid/req_ready       request handshake (single outstanding)
//   req_write/addr/wdata      request payload
//   resp_valid/resp_ready     response handshake
//   resp_rdata/resp_error     response payload (rdata 0 on writes/errors)
//   test_done/test_pass       sticky completion status
//   test_code                 exit code (all-ones on watchdog expiry)
//   wdog_fired                sticky: watchdog ended the test
module zqh_test_status_ctrl
    import zqh_test_status_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 12,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       WDOG_W   = 32,
    parameter logic [WDOG_W-1:0] WDOG_RST = 'hFFFF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic              test_done,
    output logic              test_pass,
    output logic [DATA_W-2:0] test_code,
    output logic              wdog_fired
);

    bus_state_t        r_state;
    bus_state_t        w_state_nxt;

    logic [DATA_W-1:0] r_tohost;
    logic [WDOG_W-1:0] r_limit;
    logic              r_done;
    logic              r_pass;
    logic [DATA_W-2:0] r_code;
    logic              r_fired;
    logic [DATA_W-1:0] r_rdata;
    logic              r_error;

    logic              w_accept;
    logic              w_sel_tohost;
    logic              w_sel_hb;
    logic              w_sel_limit;
    logic              w_sel_status;
    logic              w_mapped;
    logic              w_wr_tohost;
    logic              w_wr_hb;
    logic              w_wr_limit;
    logic              w_sw_done;
    logic              w_expire;
    logic [DATA_W-1:0] w_status;
    logic [DATA_W-1:0] w_rd_data;

    // ---------------------------------------------------------------
    // Handshake FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Address decode and register read mux
    // ---------------------------------------------------------------
    assign w_accept     = req_valid & (r_state == IDLE);
    assign w_sel_tohost = (req_addr == ADDR_W'(OFF_TOHOST));
    assign w_sel_hb     = (req_addr == ADDR_W'(OFF_HEARTBEAT));
    assign w_sel_limit  = (req_addr == ADDR_W'(OFF_WDOG_LIMIT));
    assign w_sel_status = (req_addr == ADDR_W'(OFF_STATUS));
    assign w_mapped     = w_sel_tohost | w_sel_hb | w_sel_limit | w_sel_status;

    assign w_wr_tohost  = w_accept & req_write & w_sel_tohost;
    assign w_wr_hb      = w_accept & req_write & w_sel_hb;
    assign w_wr_limit   = w_accept & req_write & w_sel_limit;

    // Software completion only counts the first time; done is sticky.
    assign w_sw_done    = w_wr_tohost & req_wdata[0] & ~r_done;

    always_comb begin
        w_status                 = '0;
        w_status[STAT_DONE_BIT]  = r_done;
        w_status[STAT_PASS_BIT]  = r_pass;
        w_status[STAT_FIRED_BIT] = r_fired;
    end

    always_comb begin
        w_rd_data = '0;
        if (!req_write) begin
            if (w_sel_tohost) begin
                w_rd_data = r_tohost;
            end else if (w_sel_limit) begin
                w_rd_data = DATA_W'(r_limit);
            end else if (w_sel_status) begin
                w_rd_data = w_status;
            end
        end
    end

    // ---------------------------------------------------------------
    // Watchdog
    // ---------------------------------------------------------------
    zqh_test_status_wdog #(
        .WDOG_W (WDOG_W)
    ) u_wdog (
        .i_clk    (clock),
        .i_rst    (reset),
        .i_enable (~r_done),
        .i_clear  (w_wr_hb | w_wr_limit),
        .i_limit  (r_limit),
        .o_expire (w_expire)
    );

    // ---------------------------------------------------------------
    // Register state
    // ---------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tohost <= '0;
            r_limit  <= WDOG_RST;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_code   <= '0;
            r_fired  <= 1'b0;
            r_rdata  <= '0;
            r_error  <= 1'b0;
        end else begin
            // Response payload is captured at acceptance and held in RESP.
            if (w_accept) begin
                r_rdata <= w_rd_data;
                r_error <= ~w_mapped;
            end
            if (w_wr_tohost) begin
                r_tohost <= req_wdata;
            end
            if (w_wr_limit) begin
                r_limit <= WDOG_W'(req_wdata);
            end
            // Software completion wins over a same-cycle watchdog expiry.
            if (w_sw_done) begin
                r_done <= 1'b1;
                r_code <= req_wdata[DATA_W-1:1];
                r_pass <= (req_wdata[DATA_W-1:1] == '0);
            end else if (w_expire) begin
                r_done  <= 1'b1;
                r_pass  <= 1'b0;
                r_fired <= 1'b1;
                r_code  <= '1;
            end
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_error = r_error;
    assign test_done  = r_done;
    assign test_pass  = r_pass;
    assign test_code  = r_code;
    assign wdog_fired = r_fired;

endmodule
